// File: rtl/md_issue_ctrl_if.sv
// Pipeline <-> MD issue controller signal bundle.
// slave = the controller; master = the pipeline/MD-unit side that feeds it.
interface md_issue_ctrl_if #(
  parameter int CNT_W = 5
);
  logic [31:0]      instr_d;
  logic             stall_ext;
  logic             md_busy_in;
  logic             stall_md;
  logic             md_start;
  logic             md_is_mul;
  logic             md_is_div;
  logic             md_signed;
  logic             hl_we;
  logic             hl_sel_hi;
  logic             md_busy;
  logic [CNT_W-1:0] md_cnt;
  logic             sync_err;

  modport master (
    output instr_d, stall_ext, md_busy_in,
    input  stall_md, md_start, md_is_mul, md_is_div, md_signed,
           hl_we, hl_sel_hi, md_busy, md_cnt, sync_err
  );

  modport slave (
    input  instr_d, stall_ext, md_busy_in,
    output stall_md, md_start, md_is_mul, md_is_div, md_signed,
           hl_we, hl_sel_hi, md_busy, md_cnt, sync_err
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// MD issue controller: D->E class register (1 cycle), strobes decoded from E, shadow latency counter.
// Backpressure: stall_md holds an MD-class op in D while an op is starting or in flight; a bubble enters E.
module md_issue_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 5
) (
  input  logic           clk,
  input  logic           reset,
  md_issue_ctrl_if.slave md
);

  typedef enum logic [3:0] {
    C_NONE, C_MULT, C_MULTU, C_DIV, C_DIVU, C_MFHI, C_MFLO, C_MTHI, C_MTLO
  } md_cls_e;

  localparam logic [CNT_W-1:0] L_MUL   = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] L_DIV   = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  md_cls_e          r_e_cls;
  md_cls_e          w_e_nxt;
  md_cls_e          w_d_cls;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sync_err;
  logic             w_d_is_md;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_start;
  logic             w_busy;
  logic             w_stall_md;
  logic             w_unused_instr;

  assign w_unused_instr = ^md.instr_d[25:6];

  always_comb begin
    w_d_cls = C_NONE;
    if (md.instr_d[31:26] == 6'd0) begin
      case (md.instr_d[5:0])
        6'h18:   w_d_cls = C_MULT;
        6'h19:   w_d_cls = C_MULTU;
        6'h1A:   w_d_cls = C_DIV;
        6'h1B:   w_d_cls = C_DIVU;
        6'h10:   w_d_cls = C_MFHI;
        6'h11:   w_d_cls = C_MTHI;
        6'h12:   w_d_cls = C_MFLO;
        6'h13:   w_d_cls = C_MTLO;
        default: w_d_cls = C_NONE;
      endcase
    end
  end

  assign w_d_is_md  = (w_d_cls != C_NONE);
  assign w_is_mul   = (r_e_cls == C_MULT) || (r_e_cls == C_MULTU);
  assign w_is_div   = (r_e_cls == C_DIV)  || (r_e_cls == C_DIVU);
  assign w_start    = w_is_mul || w_is_div;
  assign w_busy     = (r_cnt != '0);
  // HI/LO accesses must wait for the unit too, so any MD class stalls behind an op in flight.
  assign w_stall_md = w_d_is_md && (w_start || w_busy);

  always_comb begin
    w_e_nxt = C_NONE;
    if (!w_stall_md && !md.stall_ext) begin
      w_e_nxt = w_d_cls;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_e_cls <= C_NONE;
    end else begin
      r_e_cls <= w_e_nxt;
    end
  end

  // A start always reloads, even if a stale count is somehow still running.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= w_is_mul ? L_MUL : L_DIV;
    end else if (w_busy) begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_err <= 1'b0;
    end else if (w_busy != md.md_busy_in) begin
      r_sync_err <= 1'b1;
    end
  end

  assign md.stall_md  = w_stall_md;
  assign md.md_start  = w_start;
  assign md.md_is_mul = w_is_mul;
  assign md.md_is_div = w_is_div;
  assign md.md_signed = (r_e_cls == C_MULT) || (r_e_cls == C_DIV);
  assign md.hl_we     = (r_e_cls == C_MTHI) || (r_e_cls == C_MTLO);
  assign md.hl_sel_hi = (r_e_cls == C_MTHI) || (r_e_cls == C_MFHI);
  assign md.md_busy   = w_busy;
  assign md.md_cnt    = r_cnt;
  assign md.sync_err  = r_sync_err;

endmodule
